// File: rtl/ysyx_22051145_id_ex_stage.sv
// Decode->execute pipeline register with a two-entry skid buffer.
// MAIN drives the ALU operand ports, SKID absorbs the one extra instruction
// that can arrive while EX stalls, so id_ready is a pure register output.
`ifndef DECINFO_WIDTH
`define DECINFO_WIDTH 16
`endif

module ysyx_22051145_id_ex_stage #(
    parameter int XLEN  = 64,
    parameter int DEC_W = `DECINFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_op1,
    input  logic [XLEN-1:0]  id_op2,
    input  logic [DEC_W-1:0] id_dec_info,
    input  logic [4:0]       id_rd,
    input  logic             id_rd_wen,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_op1,
    output logic [XLEN-1:0]  ex_op2,
    output logic [DEC_W-1:0] ex_dec_info,
    output logic [4:0]       ex_rd,
    output logic             ex_rd_wen
);

    // One instruction worth of payload, as carried through MAIN and SKID.
    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  op1;
        logic [XLEN-1:0]  op2;
        logic [DEC_W-1:0] dec_info;
        logic [4:0]       rd;
        logic             rd_wen;
    } payload_t;

    // State encoding is {main_v, skid_v}; SKID is never valid without MAIN.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b10,
        ST_FULL  = 2'b11
    } state_t;

    state_t   r_state;
    state_t   w_state_nxt;
    logic     r_id_ready;
    payload_t r_main;
    payload_t r_skid;
    payload_t w_id_payload;
    logic     w_main_v;
    logic     w_in;
    logic     w_out;
    logic     w_load_main_id;
    logic     w_load_main_skid;
    logic     w_load_skid;

    assign w_id_payload.pc       = id_pc;
    assign w_id_payload.op1      = id_op1;
    assign w_id_payload.op2      = id_op2;
    assign w_id_payload.dec_info = id_dec_info;
    assign w_id_payload.rd       = id_rd;
    assign w_id_payload.rd_wen   = id_rd_wen;

    assign w_main_v = (r_state != ST_EMPTY);
    // Handshakes: the upstream side only ever sees the registered ready.
    assign w_in     = id_valid & r_id_ready;
    assign w_out    = w_main_v & ex_ready;

    // Next-state and payload load selection; flush overrides every transfer.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_id   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in) begin
                        w_state_nxt    = ST_BUSY;
                        w_load_main_id = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_BUSY: begin
                    if (w_in && w_out) begin
                        w_state_nxt    = ST_BUSY;
                        w_load_main_id = 1'b1;
                    end else if (w_in) begin
                        w_state_nxt = ST_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_out) begin
                        w_state_nxt = ST_EMPTY;
                    end else begin
                        w_state_nxt = ST_BUSY;
                    end
                end
                ST_FULL: begin
                    if (w_out) begin
                        w_state_nxt      = ST_BUSY;
                        w_load_main_skid = 1'b1;
                    end else begin
                        w_state_nxt = ST_FULL;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // Occupancy state and the registered upstream ready derived from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EMPTY;
            r_id_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_id_ready <= (w_state_nxt != ST_FULL);
        end
    end

    // MAIN payload: refilled from decode or promoted from SKID, otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
        end else if (w_load_main_id) begin
            r_main <= w_id_payload;
        end else if (w_load_main_skid) begin
            r_main <= r_skid;
        end else begin
            r_main <= r_main;
        end
    end

    // SKID payload: captures the instruction that arrives while EX is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid <= '0;
        end else if (w_load_skid) begin
            r_skid <= w_id_payload;
        end else begin
            r_skid <= r_skid;
        end
    end

    // Outputs come straight from registers; control-like fields are gated by
    // MAIN valid so a bubble reaches the ALU as dec_info 0 and no writeback.
    assign id_ready    = r_id_ready;
    assign ex_valid    = w_main_v;
    assign ex_pc       = r_main.pc;
    assign ex_op1      = r_main.op1;
    assign ex_op2      = r_main.op2;
    assign ex_dec_info = w_main_v ? r_main.dec_info : {DEC_W{1'b0}};
    assign ex_rd       = r_main.rd;
    assign ex_rd_wen   = w_main_v & r_main.rd_wen;

endmodule
